sipo_deser: RTL and testbench

Parametrised serial-in/parallel-out deserialiser, successor to the fixed 4-bit SIPO used in the multiplier datapath. It accumulates qualified serial bits into a WIDTH-bit word in configurable bit order, presents each completed word in a holding register under a valid/ready handshake, and flags overrun when downstream stalls. It sits between the serial operand input and the multiplier operand registers.

---
 rtl/sipo_deser.sv | 95 +++++++++
 tb/tb_sipo_deser.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with valid/ready holding register and sticky overrun.
// Optional even-parity trailer bit per word when SIPO_PARITY_EN is defined.
module sipo_deser #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         data_in,
   input  logic                         flush,
   output logic [WIDTH-1:0]             data_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
   output logic                         overrun,
   output logic                         parity_err
);

   localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_EN
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif

   logic [WIDTH-1:0] sr, sr_nxt, word;
   logic             last, free;

   always_comb begin
      sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], data_in} : {data_in, sr[WIDTH-1:1]};
      last   = in_valid && !flush && (bit_cnt == CW'(LAST));
      free   = !out_valid || out_ready;
`ifdef SIPO_PARITY_EN
      // the completing edge carries the parity bit, so the data bits are already in sr
      word   = sr;
`else
      word   = sr_nxt;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr        <= '0;
         bit_cnt   <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (flush) begin
            sr      <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
         end else if (in_valid) begin
            if (last) begin
               sr      <= '0;
               bit_cnt <= '0;
               if (free) begin
                  data_out  <= word;
                  out_valid <= 1'b1;
               end else begin
                  overrun   <= 1'b1;
               end
            end else begin
               sr      <= sr_nxt;
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

`ifdef SIPO_PARITY_EN
   logic par_acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_acc    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (flush || last)
            par_acc <= 1'b0;
         else if (in_valid)
            par_acc <= par_acc ^ data_in;
         // parity_err travels with data_out, so it only loads when the word does
         if (last && free)
            parity_err <= par_acc ^ data_in;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus; table vectors,
// hand sequences and random traffic checked against a word-level queue model.
module tb_sipo_deser;
   localparam int WIDTH = 4;
   localparam int CW    = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic clk = 1'b0;
   logic rst, in_valid, data_in, flush, out_ready;
   logic [WIDTH-1:0] dm, dl;
   logic vm, vl, om, ol, pm, pl;
   logic [CW-1:0] cm, cl;

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .flush(flush),
      .data_out(dm), .out_valid(vm), .out_ready(out_ready), .bit_cnt(cm),
      .overrun(om), .parity_err(pm));
   sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .flush(flush),
      .data_out(dl), .out_valid(vl), .out_ready(out_ready), .bit_cnt(cl),
      .overrun(ol), .parity_err(pl));

   int checks = 0;
   int errors = 0;

   // reference model: collected bits as a queue, holding register as plain variables
   bit q[$];
   bit hv, ovr, perr;
   int hd_m, hd_l;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete(); hv = 0; ovr = 0; perr = 0; hd_m = 0; hd_l = 0;
   endtask

   task automatic model_step(input bit iv, input bit d, input bit fl, input bit rdy);
      bit was_hv;
      int wm, wl;
      bit p;
      was_hv = hv;
      if (hv && rdy) hv = 0;
      if (fl) begin
         q.delete(); ovr = 0;
      end else if (iv) begin
         q.push_back(d);
         if (q.size() == NB) begin
            wm = 0; wl = 0; p = 0;
            for (int i = 0; i < WIDTH; i++) begin
               wm += int'(q[i]) * (1 << (WIDTH-1-i));
               wl += int'(q[i]) * (1 << i);
            end
            for (int i = 0; i < NB; i++) p ^= q[i];
            q.delete();
            if (!was_hv || rdy) begin
               hv = 1; hd_m = wm; hd_l = wl;
`ifdef SIPO_PARITY_EN
               perr = p;
`endif
            end else begin
               ovr = 1;
            end
         end
      end
   endtask

   task automatic cmp_model();
      chk("msb_data", int'(dm), hd_m);
      chk("lsb_data", int'(dl), hd_l);
      chk("msb_valid", int'(vm), int'(hv));
      chk("lsb_valid", int'(vl), int'(hv));
      chk("msb_cnt", int'(cm), q.size());
      chk("lsb_cnt", int'(cl), q.size());
      chk("msb_ovr", int'(om), int'(ovr));
      chk("lsb_ovr", int'(ol), int'(ovr));
      chk("msb_perr", int'(pm), int'(perr));
      chk("lsb_perr", int'(pl), int'(perr));
   endtask

   task automatic step(input bit iv, input bit d, input bit fl, input bit rdy);
      in_valid = iv; data_in = d; flush = fl; out_ready = rdy;
      @(posedge clk);
      model_step(iv, d, fl, rdy);
      #1;
      cmp_model();
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("rst_data_m", int'(dm), 0);
      chk("rst_data_l", int'(dl), 0);
      chk("rst_valid", int'(vm), 0);
      chk("rst_cnt", int'(cm), 0);
      chk("rst_ovr", int'(om), 0);
      chk("rst_perr", int'(pm), 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      bit iv, d, fl, rdy;
      int e_dm, e_dl;
      bit e_v, e_o;
      int e_cnt;
   } vec_t;

   initial begin
      vec_t tbl[$];
      rst = 1'b1; in_valid = 0; data_in = 0; flush = 0; out_ready = 0;
      #1;
      do_reset();
      @(posedge clk); #1;

`ifndef SIPO_PARITY_EN
      tbl = '{
         '{1,1,0,1, 0,0,   0,0, 1},
         '{1,0,0,1, 0,0,   0,0, 2},
         '{1,1,0,1, 0,0,   0,0, 3},
         '{1,1,0,1, 'hB,'hD, 1,0, 0},
         '{0,0,0,1, 'hB,'hD, 0,0, 0},
         '{1,1,0,0, 'hB,'hD, 0,0, 1},
         '{1,0,0,0, 'hB,'hD, 0,0, 2},
         '{1,1,0,0, 'hB,'hD, 0,0, 3},
         '{1,1,0,0, 'hB,'hD, 1,0, 0},
         '{1,0,0,0, 'hB,'hD, 1,0, 1},
         '{1,1,0,0, 'hB,'hD, 1,0, 2},
         '{1,1,0,0, 'hB,'hD, 1,0, 3},
         '{1,0,0,0, 'hB,'hD, 1,1, 0},
         '{1,1,1,0, 'hB,'hD, 1,0, 0},
         '{1,0,0,0, 'hB,'hD, 1,0, 1},
         '{1,1,0,0, 'hB,'hD, 1,0, 2},
         '{1,1,0,0, 'hB,'hD, 1,0, 3},
         '{1,0,0,1, 'h6,'h6, 1,0, 0},
         '{0,0,0,1, 'h6,'h6, 0,0, 0}
      };
      foreach (tbl[i]) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].rdy);
         chk("tbl_data_m", int'(dm), tbl[i].e_dm);
         chk("tbl_data_l", int'(dl), tbl[i].e_dl);
         chk("tbl_valid", int'(vm), int'(tbl[i].e_v));
         chk("tbl_ovr", int'(om), int'(tbl[i].e_o));
         chk("tbl_cnt", int'(cm), tbl[i].e_cnt);
      end

      // asynchronous reset mid-word, then a clean word of ones
      step(1,1,0,0); step(1,0,0,0);
      do_reset();
      for (int i = 0; i < 4; i++) step(1,1,0,0);
      chk("post_rst_word", int'(dm), 'hF);
      chk("post_rst_valid", int'(vm), 1);
`else
      for (int i = 0; i < 5; i++) step(1, (i == 1) ? 1'b0 : 1'b1, 0, 1);
      chk("par_ok_data", int'(dm), 'hB);
      chk("par_ok_err", int'(pm), 0);
      for (int i = 0; i < 5; i++) step(1, (i == 1 || i == 4) ? 1'b0 : 1'b1, 0, 1);
      chk("par_bad_data", int'(dm), 'hB);
      chk("par_bad_err", int'(pm), 1);
`endif

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++)
         step($urandom_range(0,3) != 0, 1'($urandom), $urandom_range(0,19) == 0,
              $urandom_range(0,1) == 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
